// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32 instruction encoder.
// Holds the imm_sel format codes, the NOP word emitted for illegal formats and an
// immediate decoder that recovers the sign-extended immediate from a packed word.
// Optional feature macro used by instr_encoder: INSTR_ENCODER_RANGE_CHECK_EN.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    ImmI = 3'b000,
    ImmS = 3'b001,
    ImmB = 3'b010,
    ImmU = 3'b011,
    ImmJ = 3'b100,
    ImmR = 3'b101
  } imm_sel_e;

  // addi x0, x0, 0
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  // Recover the immediate carried by an encoded word of the given format.
  // R-type and illegal formats carry no immediate and decode to zero.
  function automatic logic [31:0] decode_imm(input logic [2:0] sel, input logic [31:0] ins);
    logic [31:0] val;
    val = '0;
    case (sel)
      ImmI: val = {{20{ins[31]}}, ins[31:20]};
      ImmS: val = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      ImmB: val = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      ImmU: val = {ins[31:12], 12'h000};
      ImmJ: val = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Purely combinational RV32 field packer.
// Ports:
//   imm_sel  - format select (I/S/B/U/J/R, 110/111 illegal)
//   imm      - immediate; only the bits the format uses are packed
//   opcode, rd, rs1, rs2, funct3, funct7 - instruction fields
//   instr    - packed instruction word (NOP for illegal formats)
//   illegal  - set when imm_sel is not a defined format
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  imm_sel,
  input  logic [31:0] imm,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output logic [31:0] instr,
  output logic        illegal
);

  always_comb begin
    instr   = NopInstr;
    illegal = 1'b0;
    unique case (imm_sel)
      ImmI: instr = {imm[11:0], rs1, funct3, rd, opcode};
      ImmS: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      ImmB: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      ImmU: instr = {imm[31:12], rd, opcode};
      ImmJ: instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      ImmR: instr = {funct7, rs2, rs1, funct3, rd, opcode};
      default: begin
        instr   = NopInstr;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage pipelined RV32 instruction encoder with valid/ready handshakes.
// S1 captures the request (and range-checks the immediate when enabled); S2 holds the
// packed word. An accepted request is presented on out_valid two cycles later.
// Optional feature: define INSTR_ENCODER_RANGE_CHECK_EN to flag out-of-range or
// misaligned immediates on err. Without it err only flags illegal imm_sel.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid, in_ready  - request handshake
//   imm_sel, imm, opcode, rd, rs1, rs2, funct3, funct7 - request fields
//   out_valid, out_ready - result handshake
//   instr, err          - result word and error flag
//   enc_count           - number of completed result handshakes (wraps)
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       imm_sel,
  input  logic [31:0]      imm,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             err,
  output logic [CNT_W-1:0] enc_count
);

  logic        s1_valid_q;
  logic [2:0]  s1_sel_q;
  logic [31:0] s1_imm_q;
  logic [6:0]  s1_opcode_q;
  logic [4:0]  s1_rd_q;
  logic [4:0]  s1_rs1_q;
  logic [4:0]  s1_rs2_q;
  logic [2:0]  s1_funct3_q;
  logic [6:0]  s1_funct7_q;
  logic        s1_rerr;

  logic             s2_valid_q;
  logic [31:0]      instr_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic        s2_load;
  logic        in_fire;
  logic        out_fire;
  logic [31:0] pack_instr;
  logic        pack_illegal;

  // S2 can take a new word when empty or when its current word leaves this cycle.
  always_comb begin
    s2_load  = !s2_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_load;
    in_fire  = in_valid && in_ready;
    out_fire = s2_valid_q && out_ready;
  end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  logic range_err;
  logic s1_rerr_q;

  // Immediate must fit the format's signed field; branch/jump offsets must be even,
  // and U immediates must have no low bits the encoding would drop.
  always_comb begin
    range_err = 1'b0;
    unique case (imm_sel)
      ImmI, ImmS: range_err = (imm[31:11] != {21{imm[11]}});
      ImmB:       range_err = (imm[31:12] != {20{imm[12]}}) || imm[0];
      ImmJ:       range_err = (imm[31:20] != {12{imm[20]}}) || imm[0];
      ImmU:       range_err = (imm[11:0] != 12'h000);
      default:    range_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rerr_q <= 1'b0;
    end else if (in_fire) begin
      s1_rerr_q <= range_err;
    end
  end

  assign s1_rerr = s1_rerr_q;
`else
  assign s1_rerr = 1'b0;
`endif

  instr_pack u_pack (
    .imm_sel (s1_sel_q),
    .imm     (s1_imm_q),
    .opcode  (s1_opcode_q),
    .rd      (s1_rd_q),
    .rs1     (s1_rs1_q),
    .rs2     (s1_rs2_q),
    .funct3  (s1_funct3_q),
    .funct7  (s1_funct7_q),
    .instr   (pack_instr),
    .illegal (pack_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sel_q    <= '0;
      s1_imm_q    <= '0;
      s1_opcode_q <= '0;
      s1_rd_q     <= '0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_funct3_q <= '0;
      s1_funct7_q <= '0;
      s2_valid_q  <= 1'b0;
      instr_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (in_fire) begin
        s1_valid_q  <= 1'b1;
        s1_sel_q    <= imm_sel;
        s1_imm_q    <= imm;
        s1_opcode_q <= opcode;
        s1_rd_q     <= rd;
        s1_rs1_q    <= rs1;
        s1_rs2_q    <= rs2;
        s1_funct3_q <= funct3;
        s1_funct7_q <= funct7;
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end

      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          instr_q <= pack_instr;
          err_q   <= pack_illegal | s1_rerr;
        end
      end

      if (out_fire) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign instr     = instr_q;
  assign err       = err_q;
  assign enc_count = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int unsigned CntW = 4;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  localparam bit RangeEn = 1'b1;
`else
  localparam bit RangeEn = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      imm_sel;
  logic [31:0]     imm;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     instr;
  logic            err;
  logic [CntW-1:0] enc_count;

  instr_encoder #(.CNT_W(CntW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm_sel   (imm_sel),
    .imm       (imm),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .err       (err),
    .enc_count (enc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [31:0] imm;
    logic [2:0]  sel;
    bit          rt;
  } exp_t;

  exp_t            sb[$];
  int              checks_total;
  int              checks_passed;
  logic [CntW-1:0] exp_cnt;
  bit              rt_mode;

  // Reference packer, built bit-field by bit-field.
  function automatic logic [31:0] model_instr(input logic [2:0] sel, input logic [31:0] im,
      input logic [6:0] opc, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [2:0] f3, input logic [6:0] f7);
    logic [31:0] w;
    w = 32'h0;
    w[6:0] = opc;
    case (sel)
      3'd0: begin
        w[31:20] = im[11:0]; w[19:15] = s1; w[14:12] = f3; w[11:7] = d;
      end
      3'd1: begin
        w[31:25] = im[11:5]; w[24:20] = s2; w[19:15] = s1; w[14:12] = f3; w[11:7] = im[4:0];
      end
      3'd2: begin
        w[31] = im[12]; w[30:25] = im[10:5]; w[24:20] = s2; w[19:15] = s1; w[14:12] = f3;
        w[11:8] = im[4:1]; w[7] = im[11];
      end
      3'd3: begin
        w[31:12] = im[31:12]; w[11:7] = d;
      end
      3'd4: begin
        w[31] = im[20]; w[30:21] = im[10:1]; w[20] = im[11]; w[19:12] = im[19:12];
        w[11:7] = d;
      end
      3'd5: begin
        w[31:25] = f7; w[24:20] = s2; w[19:15] = s1; w[14:12] = f3; w[11:7] = d;
      end
      default: w = 32'h0000_0013;
    endcase
    return w;
  endfunction

  function automatic logic model_err(input logic [2:0] sel, input logic [31:0] im);
    int  s;
    bit  rerr;
    s = $signed(im);
    rerr = 1'b0;
    case (sel)
      3'd0, 3'd1: rerr = (s < -2048) || (s > 2047);
      3'd2:       rerr = (s < -4096) || (s > 4095) || im[0];
      3'd3:       rerr = (im[11:0] != 12'h0);
      3'd4:       rerr = (s < -1048576) || (s > 1048575) || im[0];
      default:    rerr = 1'b0;
    endcase
    return (sel > 3'd5) || (RangeEn && rerr);
  endfunction

  // Scoreboard: push expectations on input handshake, compare on output handshake.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        exp_cnt = '0;
      end else begin
        if (out_valid && out_ready) begin
          checks_total++;
          if (enc_count !== exp_cnt)
            $display("FAIL sb_count: got %0d expected %0d", enc_count, exp_cnt);
          else checks_passed++;
          checks_total++;
          if (sb.size() == 0) begin
            $display("FAIL sb_underflow: got result %h with no request outstanding", instr);
          end else begin
            e = sb.pop_front();
            if (instr !== e.instr || err !== e.err)
              $display("FAIL sb_result: got instr=%h err=%b expected instr=%h err=%b",
                       instr, err, e.instr, e.err);
            else checks_passed++;
            if (e.rt) begin
              checks_total++;
              if (decode_imm(e.sel, instr) !== e.imm)
                $display("FAIL round_trip sel=%0d: got %h expected %h", e.sel,
                         decode_imm(e.sel, instr), e.imm);
              else checks_passed++;
            end
          end
          exp_cnt = exp_cnt + 1'b1;
        end
        if (in_valid && in_ready) begin
          e.instr = model_instr(imm_sel, imm, opcode, rd, rs1, rs2, funct3, funct7);
          e.err   = model_err(imm_sel, imm);
          e.imm   = imm;
          e.sel   = imm_sel;
          e.rt    = rt_mode && (imm_sel < 3'd5);
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic set_fields(input logic [2:0] sel, input logic [31:0] im);
    imm_sel = sel;
    imm     = im;
    opcode  = 7'($urandom);
    rd      = 5'($urandom);
    rs1     = 5'($urandom);
    rs2     = 5'($urandom);
    funct3  = 3'($urandom);
    funct7  = 7'($urandom);
  endtask

  // Offer the current fields until accepted; returns at posedge+1 after the handshake.
  task automatic send(input bit rnd_ready, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_out(output bit got);
    got = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain(output bit ok);
    out_ready = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else checks_passed++;
    checks_total++;
    if (instr !== 32'h0) $display("FAIL reset_instr: got %h expected 00000000", instr);
    else checks_passed++;
    checks_total++;
    if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err);
    else checks_passed++;
    checks_total++;
    if (enc_count !== '0) $display("FAIL reset_count: got %0d expected 0", enc_count);
    else checks_passed++;
    rst_n = 1'b1;
    @(negedge clk);
    checks_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else checks_passed++;
  endtask

  task automatic test_i_example();
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    set_fields(3'd0, 32'hFFFF_FFFF);
    rs1 = 5'd2; rd = 5'd1; funct3 = 3'd0; opcode = 7'h13;
    in_valid = 1'b1;
    @(negedge clk);
    checks_total++;
    if (in_ready !== 1'b1) $display("FAIL i_accept: got in_ready=%b expected 1", in_ready);
    else checks_passed++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks_total++;
    if (out_valid !== 1'b0) $display("FAIL i_latency_early: got out_valid=%b expected 0", out_valid);
    else checks_passed++;
    @(negedge clk);
    checks_total++;
    if (out_valid !== 1'b1) $display("FAIL i_latency: got out_valid=%b expected 1", out_valid);
    else checks_passed++;
    checks_total++;
    if (instr !== 32'hFFF1_0093) $display("FAIL i_instr: got %h expected fff10093", instr);
    else checks_passed++;
    checks_total++;
    if (err !== 1'b0) $display("FAIL i_err: got %b expected 0", err);
    else checks_passed++;
  endtask

  task automatic test_b_boundary();
    bit ok;
    bit got;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    set_fields(3'd2, 32'hFFFF_F000);
    send(1'b0, ok);
    wait_out(got);
    checks_total++;
    if (!ok || !got) $display("FAIL b_timeout: got accepted=%b delivered=%b expected 1 1", ok, got);
    else checks_passed++;
    checks_total++;
    if (instr[31] !== 1'b1 || instr[7] !== 1'b0 || instr[30:25] !== 6'h0 || instr[11:8] !== 4'h0)
      $display("FAIL b_min_bits: got [31]=%b [7]=%b [30:25]=%h [11:8]=%h expected 1 0 00 0",
               instr[31], instr[7], instr[30:25], instr[11:8]);
    else checks_passed++;
    checks_total++;
    if (err !== 1'b0) $display("FAIL b_min_err: got %b expected 0", err);
    else checks_passed++;
    @(posedge clk);
    #1;
    set_fields(3'd2, 32'd3);
    send(1'b0, ok);
    wait_out(got);
    checks_total++;
    if (!got || err !== RangeEn) $display("FAIL b_odd_err: got %b expected %b", err, RangeEn);
    else checks_passed++;
  endtask

  task automatic test_illegal();
    bit ok;
    bit got;
    for (int s = 6; s < 8; s++) begin
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      set_fields(3'(s), $urandom);
      send(1'b0, ok);
      wait_out(got);
      checks_total++;
      if (!got || instr !== 32'h0000_0013 || err !== 1'b1)
        $display("FAIL illegal_sel%0d: got instr=%h err=%b expected 00000013 1", s, instr, err);
      else checks_passed++;
    end
  endtask

  task automatic load_req(input int k);
    case (k)
      0: set_fields(3'd0, 32'd5);
      1: set_fields(3'd1, -32'sd7);
      default: set_fields(3'd5, 32'd0);
    endcase
  endtask

  task automatic test_backpressure();
    int          acc;
    int          bad;
    bit          have_ref;
    logic [31:0] ref_instr;
    logic        ref_err;
    bit          saw2;
    bit          saw3;
    bit          drop;
    do_reset();
    out_ready = 1'b0;
    acc = 0; bad = 0; have_ref = 1'b0; saw2 = 1'b0; saw3 = 1'b0; drop = 1'b0;
    ref_instr = '0; ref_err = 1'b0;
    load_req(0);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      if (out_valid) begin
        if (!have_ref) begin
          have_ref = 1'b1; ref_instr = instr; ref_err = err;
        end else if (instr !== ref_instr || err !== ref_err) begin
          bad++;
        end
      end
      @(posedge clk);
      #1;
      if (acc < 3) load_req(acc);
    end
    @(negedge clk);
    checks_total++;
    if (acc != 2) $display("FAIL bp_accepted: got %0d expected 2", acc);
    else checks_passed++;
    checks_total++;
    if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", in_ready);
    else checks_passed++;
    checks_total++;
    if (!have_ref || bad != 0 || out_valid !== 1'b1 || instr !== ref_instr)
      $display("FAIL bp_stable: got changes=%0d out_valid=%b expected 0 changes, out_valid=1",
               bad, out_valid);
    else checks_passed++;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (in_valid && in_ready) drop = 1'b1;
      if (enc_count == 2) saw2 = 1'b1;
      if (saw2 && enc_count == 3) saw3 = 1'b1;
      @(posedge clk);
      #1;
      if (drop) in_valid = 1'b0;
    end
    checks_total++;
    if (!saw2) $display("FAIL bp_count2: got %0d expected to pass through 2", enc_count);
    else checks_passed++;
    checks_total++;
    if (!saw3 || enc_count !== 4'd3) $display("FAIL bp_count3: got %0d expected 3", enc_count);
    else checks_passed++;
  endtask

  task automatic test_midflight_reset();
    bit ok;
    bit ok2;
    out_ready = 1'b0;
    set_fields(3'd3, 32'h1234_5000);
    send(1'b0, ok);
    set_fields(3'd4, 32'h0000_0800);
    send(1'b0, ok2);
    #2;
    rst_n = 1'b0;
    #1;
    checks_total++;
    if (out_valid !== 1'b0) $display("FAIL mid_rst_out_valid: got %b expected 0", out_valid);
    else checks_passed++;
    checks_total++;
    if (enc_count !== '0) $display("FAIL mid_rst_count: got %0d expected 0", enc_count);
    else checks_passed++;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks_total++;
    if (!ok || !ok2 || in_ready !== 1'b1)
      $display("FAIL mid_rst_in_ready: got in_ready=%b expected 1", in_ready);
    else checks_passed++;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    set_fields(3'd1, 32'h0000_07FF);
    send(1'b0, ok);
    drain(ok2);
    checks_total++;
    if (!ok || !ok2 || enc_count !== 4'd1)
      $display("FAIL mid_rst_after: got enc_count=%0d expected 1", enc_count);
    else checks_passed++;
  endtask

  task automatic test_random();
    bit          ok;
    int          timeouts;
    logic [2:0]  sel;
    logic [31:0] v;
    timeouts = 0;
    rt_mode = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 10000; n++) begin
      sel = 3'($urandom_range(0, 5));
      case (sel)
        3'd0, 3'd1: v = 32'(int'($urandom_range(0, 4095)) - 2048);
        3'd2:       v = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
        3'd3:       v = $urandom & 32'hFFFF_F000;
        3'd4:       v = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
        default:    v = $urandom;
      endcase
      set_fields(sel, v);
      send(1'b1, ok);
      if (!ok) timeouts++;
    end
    drain(ok);
    rt_mode = 1'b0;
    checks_total++;
    if (timeouts != 0 || !ok)
      $display("FAIL random_flow: got timeouts=%0d drained=%b expected 0 1", timeouts, ok);
    else checks_passed++;
  endtask

  task automatic test_count_wrap();
    bit ok;
    int timeouts;
    timeouts = 0;
    do_reset();
    out_ready = 1'b1;
    for (int n = 0; n < 17; n++) begin
      set_fields(3'd5, 32'd0);
      send(1'b0, ok);
      if (!ok) timeouts++;
    end
    drain(ok);
    checks_total++;
    if (timeouts != 0 || !ok || enc_count !== 4'd1)
      $display("FAIL count_wrap: got %0d expected 1", enc_count);
    else checks_passed++;
  endtask

  initial begin
    checks_total = 0;
    checks_passed = 0;
    exp_cnt = '0;
    rt_mode = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_fields(3'd0, 32'd0);
    fork
      monitor();
    join_none
    test_reset();
    test_i_example();
    test_b_boundary();
    test_illegal();
    test_backpressure();
    test_midflight_reset();
    test_random();
    test_count_wrap();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
